// File: rtl/axiprotocol.sv
// axiprotocol: shared AXI burst/response encodings, FSM state types and default widths.
package axiprotocol;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 3;
  localparam int BURST_W = SIZE_W - 1;
  typedef enum logic [BURST_W-1:0] {FIXED, INCR, WRAP, RSVD} burst_t;
  typedef enum logic [BURST_W-1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axi_addr_gen.sv
// axi_addr_gen: next beat address for FIXED/INCR/WRAP bursts and illegal-burst flag.
module axi_addr_gen
  import axiprotocol::*;
#(
  parameter int W = DATA_W,
  parameter int SZ = SIZE_W,
  parameter int LW = DATA_W / 8
) (
  input  logic [W-1:0]    addr,
  input  logic [LW-1:0]   len,
  input  logic [SZ-1:0]   size,
  input  logic [SZ-2:0]   burst,
  output logic [W-1:0]    nxt,
  output logic            illegal
);
  logic [W-1:0] bytes, mask, inc;
  always_comb begin
    bytes = W'(1) << size;
    mask = ((W'(len) + W'(1)) << size) - W'(1);
    inc = addr + bytes;
    nxt = burst == FIXED ? addr : burst == WRAP ? (addr & ~mask) | (inc & mask) : inc;
    // wrap needs a power-of-two beat count of at least two
    illegal = size > SZ'(2) || burst == RSVD ||
              (burst == WRAP && (len == '0 || (len & (len + 1'b1)) != '0));
  end
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3 slave over a word memory, one outstanding burst per direction.
// Define AXI_ADDR_RANGE_CHECK_EN to flag and suppress beats beyond the memory instead of aliasing.
module axi_slave_mem
  import axiprotocol::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SIZE = SIZE_W,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH/8-1:0]   AWID,
  input  logic [WIDTH-1:0]     AWADDR,
  input  logic [WIDTH/8-1:0]   AWLEN,
  input  logic [SIZE-1:0]      AWSIZE,
  input  logic [SIZE-2:0]      AWBURST,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [WIDTH/8-1:0]   WID,
  input  logic [WIDTH-1:0]     WDATA,
  input  logic [WIDTH/8-1:0]   WSTRB,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [WIDTH/8-1:0]   BID,
  output logic [SIZE-2:0]      BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  input  logic [WIDTH/8-1:0]   ARID,
  input  logic [WIDTH-1:0]     ARADDR,
  input  logic [WIDTH/8-1:0]   ARLEN,
  input  logic [SIZE-1:0]      ARSIZE,
  input  logic [SIZE-2:0]      ARBURST,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [WIDTH/8-1:0]   RID,
  output logic [WIDTH-1:0]     RDATA,
  output logic [SIZE-2:0]      RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY
);
  localparam int IW = WIDTH / 8;
  localparam int AW = $clog2(MEM_DEPTH);
`ifdef AXI_ADDR_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  function automatic logic oor(input logic [WIDTH-1:0] a);
    return RANGE_CHK && (a >= WIDTH'(MEM_DEPTH * 4));
  endfunction
  logic [WIDTH-1:0] mem [MEM_DEPTH];
  wstate_t ws;
  rstate_t rs;
  logic [IW-1:0] wid, wlen, wcnt, rlen, rcnt;
  logic [WIDTH-1:0] waddr, raddr, wnext, rnext, rfa, rd;
  logic [SIZE-1:0] wsize, rsize;
  logic [SIZE-2:0] wburst, rburst;
  logic w_ill, r_ill, werr, wfault, r_bad;
  logic unused_wid;
  assign unused_wid = ^WID;
  axi_addr_gen #(.W(WIDTH), .SZ(SIZE), .LW(IW)) wgen (
    .addr(ws == W_IDLE ? AWADDR : waddr), .len(ws == W_IDLE ? AWLEN : wlen),
    .size(ws == W_IDLE ? AWSIZE : wsize), .burst(ws == W_IDLE ? AWBURST : wburst),
    .nxt(wnext), .illegal(w_ill)
  );
  axi_addr_gen #(.W(WIDTH), .SZ(SIZE), .LW(IW)) rgen (
    .addr(rs == R_IDLE ? ARADDR : raddr), .len(rs == R_IDLE ? ARLEN : rlen),
    .size(rs == R_IDLE ? ARSIZE : rsize), .burst(rs == R_IDLE ? ARBURST : rburst),
    .nxt(rnext), .illegal(r_ill)
  );
  assign wfault = w_ill | (WLAST != (wcnt == wlen)) | oor(waddr);
  assign rfa = rs == R_IDLE ? ARADDR : rnext;
  assign r_bad = r_ill | oor(rfa);
  assign rd = r_bad ? '0 : mem[rfa[AW+1:2]];
  always_ff @(posedge clk) begin
    if (reset) begin
      ws <= W_IDLE;
      {AWREADY, WREADY, BVALID, BID, BRESP} <= '0;
      {wid, waddr, wlen, wsize, wburst, wcnt, werr} <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (ws)
        W_IDLE: begin
          AWREADY <= 1'b1;
          if (AWVALID && AWREADY) begin
            {wid, waddr, wlen, wsize, wburst} <= {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
            {wcnt, werr} <= '0;
            AWREADY <= 1'b0;
            WREADY <= 1'b1;
            ws <= W_DATA;
          end
        end
        W_DATA: if (WVALID && WREADY) begin
          if (!w_ill && !oor(waddr))
            for (int i = 0; i < IW; i++) if (WSTRB[i]) mem[waddr[AW+1:2]][8*i +: 8] <= WDATA[8*i +: 8];
          waddr <= wnext;
          wcnt <= wcnt + 1'b1;
          werr <= werr | wfault;
          if (wcnt == wlen) begin
            WREADY <= 1'b0;
            BVALID <= 1'b1;
            BID <= wid;
            BRESP <= (werr | wfault) ? SLVERR : OKAY;
            ws <= W_RESP;
          end
        end
        W_RESP: if (BREADY) begin
          BVALID <= 1'b0;
          AWREADY <= 1'b1;
          ws <= W_IDLE;
        end
        default: ws <= W_IDLE;
      endcase
    end
  end
  // RDATA is fetched at the edge that launches the beat, so a same-cycle write yields old data
  always_ff @(posedge clk) begin
    if (reset) begin
      rs <= R_IDLE;
      {ARREADY, RID, RDATA, RRESP, RLAST, RVALID} <= '0;
      {raddr, rlen, rsize, rburst, rcnt} <= '0;
    end else begin
      case (rs)
        R_IDLE: begin
          ARREADY <= 1'b1;
          if (ARVALID && ARREADY) begin
            {raddr, rlen, rsize, rburst} <= {ARADDR, ARLEN, ARSIZE, ARBURST};
            rcnt <= '0;
            ARREADY <= 1'b0;
            RVALID <= 1'b1;
            RID <= ARID;
            RDATA <= rd;
            RRESP <= r_bad ? SLVERR : OKAY;
            RLAST <= ARLEN == '0;
            rs <= R_DATA;
          end
        end
        R_DATA: if (RREADY) begin
          if (RLAST) begin
            {RVALID, RLAST} <= '0;
            ARREADY <= 1'b1;
            rs <= R_IDLE;
          end else begin
            raddr <= rnext;
            rcnt <= rcnt + 1'b1;
            RDATA <= rd;
            RRESP <= r_bad ? SLVERR : OKAY;
            RLAST <= IW'(rcnt + 1'b1) == rlen;
          end
        end
        default: rs <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: table vectors, hand sequences and random bursts against a byte-lane memory model.
module tb_axi_slave_mem;
  logic clk = 1'b0, reset;
  logic [3:0] AWID, AWLEN, WID, WSTRB, BID, ARID, ARLEN, RID;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, BRESP, ARBURST, RRESP;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  int vectors = 0, fails = 0;
  logic [31:0] ref_mem [256];
  typedef struct {
    bit rd; logic [31:0] a; logic [3:0] len; logic [2:0] size; logic [1:0] burst;
    logic [3:0] strb; int lm; logic [3:0][31:0] d; logic [1:0] resp;
  } vec_t;
  vec_t tbl[18];
  always #5 clk = ~clk;
  axi_slave_mem dut (
    .clk(clk), .reset(reset),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );
  function automatic vec_t mkv(input bit rd, input logic [31:0] a, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                               input int lm, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3, input logic [1:0] resp);
    vec_t v;
    v.rd = rd; v.a = a; v.len = len; v.size = size; v.burst = burst; v.strb = strb;
    v.lm = lm; v.d = {d3, d2, d1, d0}; v.resp = resp;
    return v;
  endfunction
  function automatic logic legal(input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    return size <= 3'd2 && burst != 2'd3 && (burst != 2'd2 || len inside {4'd1, 4'd3, 4'd7, 4'd15});
  endfunction
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [31:0] nb, blk, base;
    nb = 32'd1 << size;
    blk = (32'(len) + 32'd1) * nb;
    base = a - a % blk;
    return burst == 2'd0 ? a : burst == 2'd2 ? base + (a - base + 32'(i) * nb) % blk : a + 32'(i) * nb;
  endfunction
  function automatic logic oor(input logic [31:0] a);
`ifdef AXI_ADDR_RANGE_CHECK_EN
    return a >= 32'd1024;
`else
    return a != a;
`endif
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_rdy(input int w, input string nm);
    int n;
    n = 0;
    while (!(w == 0 ? AWREADY : w == 1 ? WREADY : ARREADY) && n < 64) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 64'(n < 64), 64'd1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    {AWVALID, WVALID, ARVALID, BREADY, RREADY, WLAST} = '0;
    tick();
    chk("rst_outputs", 64'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RID, RDATA, RRESP, RLAST, RVALID}), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    tick();
    chk("rst_awready", 64'(AWREADY), 64'd1);
    chk("rst_arready", 64'(ARREADY), 64'd1);
  endtask
  task automatic axi_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                           input int lm, input logic [15:0][31:0] d, input int bdly,
                           output logic [1:0] bresp, output logic [1:0] eresp);
    logic ok, err, last, wl;
    logic [31:0] ba;
    ok = legal(len, size, burst);
    err = !ok;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST} = {id, a, len, size, burst};
    AWVALID = 1'b1;
    wait_rdy(0, "aw");
    tick();
    AWVALID = 1'b0;
    chk("wready_latency", 64'(WREADY), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      last = i == int'(len);
      wl = lm == 0 ? last : lm == 1 ? 1'b0 : (i == 0);
      {WID, WDATA, WSTRB, WLAST} = {id, d[i], strb, wl};
      WVALID = 1'b1;
      wait_rdy(1, "w");
      ba = beat_addr(a, len, size, burst, i);
      if (ok && !oor(ba))
        for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[ba[9:2]][8*b +: 8] = d[i][8*b +: 8];
      err = err | oor(ba) | (wl != last);
      tick();
    end
    {WVALID, WLAST} = '0;
    eresp = err ? 2'b10 : 2'b00;
    chk("bvalid_latency", 64'(BVALID), 64'd1);
    for (int k = 0; k < bdly; k++) begin
      tick();
      chk("bvalid_hold", 64'({BVALID, BRESP}), 64'({1'b1, eresp}));
    end
    chk("bid", 64'(BID), 64'(id));
    bresp = BRESP;
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("bvalid_drop", 64'(BVALID), 64'd0);
  endtask
  task automatic axi_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int rdly,
                          output logic [15:0][31:0] got, output logic [15:0][1:0] gresp);
    logic ok, good;
    logic [31:0] ba, ed;
    ok = legal(len, size, burst);
    {ARID, ARADDR, ARLEN, ARSIZE, ARBURST} = {id, a, len, size, burst};
    ARVALID = 1'b1;
    wait_rdy(2, "ar");
    tick();
    ARVALID = 1'b0;
    chk("rvalid_latency", 64'(RVALID), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, len, size, burst, i);
      good = ok && !oor(ba);
      ed = good ? ref_mem[ba[9:2]] : 32'd0;
      for (int k = 0; k < rdly; k++) begin
        tick();
        chk("rvalid_hold", 64'({RVALID, RDATA}), 64'({1'b1, ed}));
      end
      chk("rvalid", 64'(RVALID), 64'd1);
      chk("rdata", 64'(RDATA), 64'(ed));
      chk("rresp", 64'(RRESP), good ? 64'd0 : 64'd2);
      chk("rlast", 64'(RLAST), 64'(i == int'(len)));
      chk("rid", 64'(RID), 64'(id));
      got[i] = RDATA;
      gresp[i] = RRESP;
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
    chk("rvalid_drop", 64'(RVALID), 64'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0][31:0] d16, got;
    logic [15:0][1:0] gresp;
    logic [1:0] bresp, eresp;
    logic [31:0] a;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, WID, WDATA, WSTRB, ARID, ARADDR, ARLEN, ARSIZE, ARBURST} = '0;
    tbl[0]  = mkv(0, 32'h10, 0, 2, 1, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0, 2'b00);
    tbl[1]  = mkv(1, 32'h10, 0, 2, 1, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0, 2'b00);
    tbl[2]  = mkv(0, 32'h20, 3, 2, 1, 4'hF, 0, 1, 2, 3, 4, 2'b00);
    tbl[3]  = mkv(1, 32'h20, 3, 2, 1, 4'hF, 0, 1, 2, 3, 4, 2'b00);
    tbl[4]  = mkv(0, 32'h30, 3, 2, 1, 4'hF, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00);
    tbl[5]  = mkv(1, 32'h38, 3, 2, 2, 4'hF, 0, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 2'b00);
    tbl[6]  = mkv(0, 32'h40, 0, 2, 1, 4'hF, 0, 32'hFFFFFFFF, 0, 0, 0, 2'b00);
    tbl[7]  = mkv(0, 32'h40, 0, 2, 1, 4'h5, 0, 32'h0, 0, 0, 0, 2'b00);
    tbl[8]  = mkv(1, 32'h40, 0, 2, 1, 4'hF, 0, 32'hFF00FF00, 0, 0, 0, 2'b00);
    tbl[9]  = mkv(0, 32'h50, 0, 2, 3, 4'hF, 0, 32'h12345678, 0, 0, 0, 2'b10);
    tbl[10] = mkv(1, 32'h50, 0, 2, 1, 4'hF, 0, 32'h0, 0, 0, 0, 2'b00);
    tbl[11] = mkv(0, 32'h60, 1, 2, 1, 4'hF, 1, 32'h11, 32'h22, 0, 0, 2'b10);
    tbl[12] = mkv(1, 32'h60, 1, 2, 1, 4'hF, 0, 32'h11, 32'h22, 0, 0, 2'b00);
    tbl[13] = mkv(1, 32'h10, 0, 3, 1, 4'hF, 0, 32'h0, 0, 0, 0, 2'b10);
    tbl[14] = mkv(0, 32'h70, 1, 2, 1, 4'hF, 2, 32'h33, 32'h44, 0, 0, 2'b10);
    tbl[15] = mkv(1, 32'h10, 2, 2, 0, 4'hF, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2'b00);
    tbl[16] = mkv(0, 32'h90, 2, 2, 2, 4'hF, 0, 5, 6, 7, 0, 2'b10);
    tbl[17] = mkv(1, 32'h90, 2, 2, 1, 4'hF, 0, 0, 0, 0, 0, 2'b00);
    reset = 1'b1;
    tick();
    do_reset();
    for (int k = 0; k < 18; k++) begin
      if (!tbl[k].rd) begin
        d16 = '0;
        d16[3:0] = tbl[k].d;
        axi_write(4'(k), tbl[k].a, tbl[k].len, tbl[k].size, tbl[k].burst, tbl[k].strb, tbl[k].lm, d16, 0, bresp, eresp);
        chk($sformatf("tbl%0d_bresp", k), 64'(bresp), 64'(tbl[k].resp));
      end else begin
        axi_read(4'(k), tbl[k].a, tbl[k].len, tbl[k].size, tbl[k].burst, 0, got, gresp);
        for (int i = 0; i <= int'(tbl[k].len); i++) begin
          chk($sformatf("tbl%0d_rdata%0d", k, i), 64'(got[i]), 64'(tbl[k].d[i]));
          chk($sformatf("tbl%0d_rresp%0d", k, i), 64'(gresp[i]), 64'(tbl[k].resp));
        end
      end
    end
    // held BREADY/RREADY must freeze the response channels
    d16 = '0;
    d16[0] = 32'hCAFEF00D;
    axi_write(4'h3, 32'hA0, 0, 2, 1, 4'hF, 0, d16, 4, bresp, eresp);
    chk("bp_bresp", 64'(bresp), 64'(eresp));
    axi_read(4'h6, 32'hA0, 0, 2, 1, 5, got, gresp);
    chk("bp_rdata", 64'(got[0]), 64'hCAFEF00D);
    // reset with a read beat pending and a write burst half done
    {ARID, ARADDR, ARLEN, ARSIZE, ARBURST} = {4'h2, 32'h20, 4'd3, 3'd2, 2'd1};
    ARVALID = 1'b1;
    wait_rdy(2, "mid_ar");
    tick();
    ARVALID = 1'b0;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST} = {4'h4, 32'h80, 4'd3, 3'd2, 2'd1};
    AWVALID = 1'b1;
    wait_rdy(0, "mid_aw");
    tick();
    AWVALID = 1'b0;
    {WDATA, WSTRB, WLAST} = {32'h55, 4'hF, 1'b0};
    WVALID = 1'b1;
    tick();
    tick();
    WVALID = 1'b0;
    do_reset();
    axi_read(4'h1, 32'h20, 1, 2, 1, 0, got, gresp);
    chk("post_rst_mem", 64'(got[0]), 64'd0);
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      len = 4'($urandom_range(0, 7));
      size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) d16[i] = $urandom;
      axi_write(4'($urandom), a, len, size, burst, 4'($urandom), ($urandom_range(0, 5) == 0) ? 1 : 0,
                d16, $urandom_range(0, 2), bresp, eresp);
      chk("rnd_bresp", 64'(bresp), 64'(eresp));
      axi_read(4'($urandom), a, len, size, burst, $urandom_range(0, 2), got, gresp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
